timer_scheduler: RTL and testbench
==================================

# timer_scheduler

Four-channel microsecond timer scheduler sharing one prescaler and one decrement datapath across all channels. A scan state machine visits each channel's count register in turn on every microsecond tick, so one subtractor serves every channel. Sits on the CPU peripheral bus next to the single-shot timers and drives one combined interrupt line into the interrupt controller.

## Interface
- CHANNELS, 4, number of channels, legal range 1..4
- BITS, 32, width of count and reload registers
- MHZ_TIMER_BITS, 5, prescaler width
- MHZ_TIMER_VALUE, 26, prescaler terminal value; tick period = MHZ_TIMER_VALUE+1 clk; must be >= CHANNELS
- clk  in  1  system clock
- nreset  in  1  synchronous, active-low reset
- nwr  in  1  active-low write strobe, one clk per access
- nrd  in  1  active-low read strobe, one clk per access
- address  in  3  register select
- data_in  in  BITS  write data
- data_out  out  BITS  registered read data
- interrupt  out  1  registered OR of (pending & ie)

## Operation
- Register map:
  - 0..CHANNELS-1 (CH): write loads count and reload. Nonzero value sets armed[i] and clears pending[i]; zero clears armed[i]. Read returns the current count.
  - 4 (CTRL): bits [3:0] = ie, bits [7:4] = periodic. Other bits read 0.
  - 5 (PEND): read returns pending in bits [3:0]. Write-1-to-clear.
  - Other addresses: reads return 0, writes are ignored.
- Bits for channels >= CHANNELS read 0 and ignore writes.
- Prescaler counts 0..MHZ_TIMER_VALUE and wraps continuously. tick = (prescaler == MHZ_TIMER_VALUE).
- FSM states:
  - IDLE: on tick, go to SCAN with idx=0.
  - SCAN: process channel idx. If idx == CHANNELS-1, go to IDLE; otherwise idx+1.
- Per-channel processing in SCAN, applied only when armed[idx]:
  - If count > 1: count <= count-1.
  - If count == 1: pending[idx] <= 1. If periodic[idx], count <= reload[idx]. Otherwise count <= 0 and armed[idx] <= 0.
- Disarmed channels are untouched.
- Arithmetic is BITS-wide unsigned; count never wraps below 0.
- Collisions:
  - CPU write to CH i in the same cycle SCAN processes i: the write wins and that scan update is discarded.
  - PEND write-1-to-clear in the same cycle a bit is set: the set wins.
  - nwr and nrd both low: the write is performed and data_out still updates.
- Writing CTRL never alters count, armed or pending.
- Reset, including mid-scan: FSM to IDLE, idx=0, prescaler=0. All count, reload, armed, ie, periodic and pending cleared. data_out=0, interrupt=0.

## Timing
- A tick occurs once per MHZ_TIMER_VALUE+1 clk. The first tick after reset is at cycle MHZ_TIMER_VALUE.
- SCAN lasts exactly CHANNELS cycles per tick. Channel i is processed i+1 cycles after the tick cycle.
- A channel loaded with N sets pending on the Nth tick after the load, during its scan slot.
- Periodic channels then fire every reload ticks.
- pending is visible in the cycle after its scan slot. interrupt rises one cycle after that.
- interrupt falls one cycle after the pending bit or ie bit clears.
- Read latency: data_out is valid the cycle after nrd is low and holds until the next read.
- Write latency: the write takes effect at the clk edge where nwr is low.

## Test plan
- Reset, then read all addresses: data_out=0 everywhere. interrupt=0 for 200 clk after reset with no channels loaded.
- CTRL=0x1, write CH0=3, one-shot: pending[0] set at the 3rd tick's slot, about 81 clk later with the default prescaler. interrupt follows 1 clk later. Read CH0=0. No further set after PEND write 0x1.
- CTRL=0x22 (ie1, periodic1), CH1=2: pending[1] sets every 2 ticks (54 clk). Clear PEND each time; CH1 reads 2 right after each fire.
- All four channels loaded with 1 at the same cycle: pending=0xF after one tick. The bits appear on consecutive cycles 1..4 after the tick.
- Write CH2=5 in the exact cycle of channel 2's scan slot: CH2 reads 5, not 4. PEND clear in the same cycle a bit sets leaves the bit at 1.
- Assert nreset mid-SCAN with channels armed: all state cleared, and there are no interrupts afterwards until a channel is reloaded.

Source files
------------

// File: rtl/timer_scheduler_if.sv
// -----------------------------------------------------------------------------
// timer_scheduler_if
// CPU peripheral bus bundle for the timer scheduler.
//   nwr       - active-low write strobe, one clk per access
//   nrd       - active-low read strobe, one clk per access
//   address   - register select
//   data_in   - write data
//   data_out  - registered read data
//   interrupt - combined channel interrupt
// master: bus driver (CPU side). slave: the timer scheduler.
// -----------------------------------------------------------------------------
interface timer_scheduler_if #(
  parameter int BITS = 32
) ();
  logic            nwr;
  logic            nrd;
  logic [2:0]      address;
  logic [BITS-1:0] data_in;
  logic [BITS-1:0] data_out;
  logic            interrupt;

  modport master (
    output nwr, nrd, address, data_in,
    input  data_out, interrupt
  );

  modport slave (
    input  nwr, nrd, address, data_in,
    output data_out, interrupt
  );
endinterface

// File: rtl/timer_scheduler.sv
// -----------------------------------------------------------------------------
// timer_scheduler
// Multi-channel microsecond timer. One prescaler produces a tick every
// MHZ_TIMER_VALUE+1 clocks; a scan FSM then visits each channel once so that a
// single decrementer serves every count register.
// Ports:
//   clk    - system clock
//   nreset - synchronous, active-low reset
//   bus    - timer_scheduler_if.slave (nwr, nrd, address, data_in,
//            data_out, interrupt)
// Register map: 0..CHANNELS-1 count/reload, 4 CTRL {periodic, ie}, 5 PEND.
// -----------------------------------------------------------------------------
module timer_scheduler #(
  parameter int CHANNELS        = 4,
  parameter int BITS            = 32,
  parameter int MHZ_TIMER_BITS  = 5,
  parameter int MHZ_TIMER_VALUE = 26
) (
  input  logic             clk,
  input  logic             nreset,
  timer_scheduler_if.slave bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;
  localparam logic [1:0] LAST_IDX  = 2'(CHANNELS - 1);
  localparam logic [3:0] CH_MASK   = 4'((1 << CHANNELS) - 1);
  localparam logic [2:0] ADDR_CTRL = 3'd4;
  localparam logic [2:0] ADDR_PEND = 3'd5;

  logic [MHZ_TIMER_BITS-1:0] prescaler_q, prescaler_d;
  logic [0:0]                state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic [BITS-1:0]           count_q [4];
  logic [BITS-1:0]           count_d [4];
  logic [BITS-1:0]           reload_q [4];
  logic [BITS-1:0]           reload_d [4];
  logic [3:0]                armed_q, armed_d;
  logic [3:0]                pending_q, pending_d;
  logic [3:0]                ie_q, ie_d;
  logic [3:0]                periodic_q, periodic_d;
  logic [BITS-1:0]           data_out_q, data_out_d;
  logic                      interrupt_q;

  logic tick;
  logic wr_en;
  logic rd_en;
  logic addr_is_ch;

  assign tick       = (prescaler_q == MHZ_TIMER_BITS'(MHZ_TIMER_VALUE));
  assign wr_en      = ~bus.nwr;
  assign rd_en      = ~bus.nrd;
  assign addr_is_ch = (bus.address < 3'(CHANNELS));

  assign prescaler_d = tick ? '0 : prescaler_q + MHZ_TIMER_BITS'(1);

  // Scan FSM: one channel per cycle after each tick. MHZ_TIMER_VALUE >= CHANNELS
  // guarantees the scan always finishes before the next tick arrives.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Channel/register update. Order matters: PEND clear is applied before the
  // scan so a set in the same cycle wins; a CH write is applied last so it
  // overrides the scan update of the same channel.
  always_comb begin
    count_d    = count_q;
    reload_d   = reload_q;
    armed_d    = armed_q;
    pending_d  = pending_q;
    ie_d       = ie_q;
    periodic_d = periodic_q;

    if (wr_en && bus.address == ADDR_PEND)
      pending_d = pending_q & ~bus.data_in[3:0];

    if (wr_en && bus.address == ADDR_CTRL) begin
      ie_d       = bus.data_in[3:0] & CH_MASK;
      periodic_d = bus.data_in[7:4] & CH_MASK;
    end

    if (state_q == ST_SCAN && armed_q[idx_q]) begin
      if (count_q[idx_q] > BITS'(1)) begin
        count_d[idx_q] = count_q[idx_q] - BITS'(1);
      end else if (count_q[idx_q] == BITS'(1)) begin
        pending_d[idx_q] = 1'b1;
        if (periodic_q[idx_q]) begin
          count_d[idx_q] = reload_q[idx_q];
        end else begin
          count_d[idx_q] = '0;
          armed_d[idx_q] = 1'b0;
        end
      end
    end

    if (wr_en && addr_is_ch) begin
      count_d[bus.address[1:0]]   = bus.data_in;
      reload_d[bus.address[1:0]]  = bus.data_in;
      armed_d[bus.address[1:0]]   = |bus.data_in;
      pending_d[bus.address[1:0]] = 1'b0;
    end
  end

  // Read mux samples pre-update state; data_out holds between reads.
  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) begin
      if (addr_is_ch)
        data_out_d = count_q[bus.address[1:0]];
      else if (bus.address == ADDR_CTRL)
        data_out_d = BITS'({periodic_q, ie_q});
      else if (bus.address == ADDR_PEND)
        data_out_d = BITS'(pending_q);
      else
        data_out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      prescaler_q <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
      armed_q     <= '0;
      pending_q   <= '0;
      ie_q        <= '0;
      periodic_q  <= '0;
      data_out_q  <= '0;
      interrupt_q <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      armed_q     <= armed_d;
      pending_q   <= pending_d;
      ie_q        <= ie_d;
      periodic_q  <= periodic_d;
      data_out_q  <= data_out_d;
      interrupt_q <= |(pending_q & ie_q);
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.interrupt = interrupt_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_timer_scheduler
// Self-checking bench for timer_scheduler. The reference model tracks the
// cycle index since reset: channel i is serviced in every cycle c >= PER with
// c % PER == i, which follows from the tick/slot timing of the block.
// -----------------------------------------------------------------------------
module tb_timer_scheduler;

  localparam int CH   = 4;
  localparam int BITS = 32;
  localparam int TV   = 26;
  localparam int PER  = TV + 1;

  logic clk    = 1'b0;
  logic nreset = 1'b0;

  timer_scheduler_if #(.BITS(BITS)) bus ();

  timer_scheduler #(
    .CHANNELS       (CH),
    .BITS           (BITS),
    .MHZ_TIMER_BITS (5),
    .MHZ_TIMER_VALUE(TV)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int          m_cyc = 0;
  logic [31:0] m_count [4];
  logic [31:0] m_reload [4];
  logic [3:0]  m_armed = '0;
  logic [3:0]  m_pend  = '0;
  logic [3:0]  m_ie    = '0;
  logic [3:0]  m_per   = '0;
  logic [31:0] m_dout  = '0;
  logic        m_irq   = 1'b0;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    if (a < 3'(CH))   return m_count[a[1:0]];
    else if (a == 3'd4) return {24'd0, m_per, m_ie};
    else if (a == 3'd5) return {28'd0, m_pend};
    else                return 32'd0;
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] nc [4];
    logic [31:0] nr [4];
    logic [3:0]  na, np, nie, nper;
    logic [31:0] nd;
    int          ch;
    if (!nreset) begin
      for (int i = 0; i < 4; i++) begin
        m_count[i]  <= '0;
        m_reload[i] <= '0;
      end
      m_armed <= '0; m_pend <= '0; m_ie <= '0; m_per <= '0;
      m_dout  <= '0; m_irq  <= 1'b0; m_cyc <= 0;
    end else begin
      nc = m_count; nr = m_reload; na = m_armed; np = m_pend;
      nie = m_ie; nper = m_per; nd = m_dout;
      if (!bus.nrd) nd = model_read(bus.address);
      if (!bus.nwr && bus.address == 3'd5) np = np & ~bus.data_in[3:0];
      if (!bus.nwr && bus.address == 3'd4) begin
        nie  = bus.data_in[3:0];
        nper = bus.data_in[7:4];
      end
      if (m_cyc >= PER && (m_cyc % PER) < CH) begin
        ch = m_cyc % PER;
        if (na[ch]) begin
          if (nc[ch] > 1) nc[ch] = nc[ch] - 1;
          else begin
            np[ch] = 1'b1;
            if (m_per[ch]) nc[ch] = m_reload[ch];
            else begin nc[ch] = 0; na[ch] = 1'b0; end
          end
        end
      end
      if (!bus.nwr && bus.address < 3'(CH)) begin
        nc[bus.address[1:0]] = bus.data_in;
        nr[bus.address[1:0]] = bus.data_in;
        na[bus.address[1:0]] = (bus.data_in != 0);
        np[bus.address[1:0]] = 1'b0;
      end
      m_count <= nc; m_reload <= nr; m_armed <= na; m_pend <= np;
      m_ie <= nie; m_per <= nper; m_dout <= nd;
      m_irq <= |(m_pend & m_ie);
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- stimulus primitives ----------------
  task automatic bus_idle();
    bus.nwr = 1'b1; bus.nrd = 1'b1; bus.address = '0; bus.data_in = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.nwr = 1'b0; bus.address = a; bus.data_in = d;
    @(negedge clk);
    bus.nwr = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    @(negedge clk);
    bus.nrd = 1'b0; bus.address = a;
    @(negedge clk);
    bus.nrd = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_idle();
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 400 && m_cyc != target; k++) @(negedge clk);
    if (m_cyc != target) begin
      n_err++;
      $display("FAIL wait_cyc: reached cycle %0d, required %0d", m_cyc, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      n_vec++;
      if (bus.data_out !== 32'd0) begin
        n_err++;
        $display("FAIL reset_read addr %0d: got %h expected 0", a, bus.data_out);
      end
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.interrupt !== 1'b0) begin
        n_err++;
        $display("FAIL reset_irq cycle %0d: got %b expected 0", k, bus.interrupt);
      end
    end
  endtask

  task automatic test_oneshot();
    int w, s3;
    wr(3'd4, 32'h1);
    wr(3'd0, 32'd3);
    w  = m_cyc - 1;
    s3 = ((w / PER) + 1) * PER + 2 * PER;
    for (int k = 0; k < 200 && bus.interrupt !== 1'b1; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.interrupt !== m_irq) begin
        n_err++;
        $display("FAIL oneshot_irq_track: got %b expected %b", bus.interrupt, m_irq);
      end
    end
    n_vec++;
    if (bus.interrupt !== 1'b1 || m_cyc != s3 + 2) begin
      n_err++;
      $display("FAIL oneshot_fire: irq %b at cycle %0d, required 1 at cycle %0d",
               bus.interrupt, m_cyc, s3 + 2);
    end
    rd(3'd0);
    n_vec++;
    if (bus.data_out !== 32'd0) begin
      n_err++;
      $display("FAIL oneshot_count: got %h expected 0", bus.data_out);
    end
    rd(3'd5);
    n_vec++;
    if (bus.data_out !== 32'h1) begin
      n_err++;
      $display("FAIL oneshot_pend: got %h expected 1", bus.data_out);
    end
    wr(3'd5, 32'h1);
    @(negedge clk);
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.interrupt !== 1'b0) begin
        n_err++;
        $display("FAIL oneshot_nofire cycle %0d: got %b expected 0", k, bus.interrupt);
      end
    end
  endtask

  task automatic test_periodic();
    int prev = -1;
    wr(3'd5, 32'hF);
    wr(3'd4, 32'h22);
    wr(3'd1, 32'd2);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 100 && bus.interrupt !== 1'b1; k++) begin
        @(negedge clk);
        n_vec++;
        if (bus.interrupt !== m_irq) begin
          n_err++;
          $display("FAIL periodic_irq_track: got %b expected %b", bus.interrupt, m_irq);
        end
      end
      n_vec++;
      if (bus.interrupt !== 1'b1 || (prev >= 0 && m_cyc - prev != 2 * PER)) begin
        n_err++;
        $display("FAIL periodic_fire %0d: irq %b interval %0d, required 1 and %0d",
                 f, bus.interrupt, m_cyc - prev, 2 * PER);
      end
      prev = m_cyc;
      rd(3'd1);
      n_vec++;
      if (bus.data_out !== 32'd2) begin
        n_err++;
        $display("FAIL periodic_reload %0d: got %h expected 2", f, bus.data_out);
      end
      wr(3'd5, 32'h2);
      @(negedge clk);
      n_vec++;
      if (bus.interrupt !== 1'b0) begin
        n_err++;
        $display("FAIL periodic_clear %0d: got %b expected 0", f, bus.interrupt);
      end
    end
  endtask

  task automatic test_all_channels();
    logic [31:0] exp;
    do_reset();
    wr(3'd4, 32'hF);
    for (int i = 0; i < CH; i++) wr(3'(i), 32'd1);
    wait_cyc(20);
    bus.nrd = 1'b0; bus.address = 3'd5;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      // PEND read in cycle c reports bits set by slots up to cycle c-2
      exp = 32'd0;
      for (int i = 0; i < CH; i++)
        if (m_cyc - 29 >= i) exp[i] = 1'b1;
      n_vec++;
      if (bus.data_out !== exp) begin
        n_err++;
        $display("FAIL all_pend cycle %0d: got %h expected %h", m_cyc, bus.data_out, exp);
      end
    end
    bus.nrd = 1'b1;
    n_vec++;
    if (bus.interrupt !== 1'b1) begin
      n_err++;
      $display("FAIL all_irq: got %b expected 1", bus.interrupt);
    end
  endtask

  task automatic test_collision();
    do_reset();
    wr(3'd2, 32'd7);
    wait_cyc(PER + 2);
    bus.nwr = 1'b0; bus.address = 3'd2; bus.data_in = 32'd5;
    @(negedge clk);
    bus.nwr = 1'b1;
    rd(3'd2);
    n_vec++;
    if (bus.data_out !== 32'd5) begin
      n_err++;
      $display("FAIL collide_ch_write: got %h expected 5", bus.data_out);
    end
    wr(3'd0, 32'd1);
    wait_cyc(2 * PER);
    bus.nwr = 1'b0; bus.address = 3'd5; bus.data_in = 32'h1;
    @(negedge clk);
    bus.nwr = 1'b1;
    rd(3'd5);
    n_vec++;
    if (bus.data_out !== 32'h1) begin
      n_err++;
      $display("FAIL collide_pend_clear: got %h expected 1", bus.data_out);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    wr(3'd4, 32'hF);
    for (int i = 0; i < CH; i++) wr(3'(i), 32'd1);
    wait_cyc(PER + 1);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    for (int a = 0; a < 6; a++) begin
      rd(3'(a));
      n_vec++;
      if (bus.data_out !== 32'd0) begin
        n_err++;
        $display("FAIL midscan_read addr %0d: got %h expected 0", a, bus.data_out);
      end
    end
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.interrupt !== 1'b0) begin
        n_err++;
        $display("FAIL midscan_irq cycle %0d: got %b expected 0", k, bus.interrupt);
      end
    end
    wr(3'd4, 32'h1);
    wr(3'd0, 32'd1);
    for (int k = 0; k < 80 && bus.interrupt !== 1'b1; k++) @(negedge clk);
    n_vec++;
    if (bus.interrupt !== 1'b1) begin
      n_err++;
      $display("FAIL midscan_reload_irq: got %b expected 1", bus.interrupt);
    end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] a;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus.data_out !== m_dout) begin
        n_err++;
        $display("FAIL random_dout cycle %0d: got %h expected %h", m_cyc, bus.data_out, m_dout);
      end
      n_vec++;
      if (bus.interrupt !== m_irq) begin
        n_err++;
        $display("FAIL random_irq cycle %0d: got %b expected %b", m_cyc, bus.interrupt, m_irq);
      end
      bus_idle();
      r = $urandom_range(0, 9);
      a = 3'($urandom_range(0, 7));
      if (r < 3) begin
        bus.nwr = 1'b0; bus.address = a;
        bus.data_in = (a < 3'(CH)) ? 32'($urandom_range(0, 3)) : $urandom;
      end else if (r < 6) begin
        bus.nrd = 1'b0; bus.address = a;
      end
    end
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_oneshot();
    test_periodic();
    test_all_channels();
    test_collision();
    test_reset_mid_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
